// File: rtl/nibble_deserializer_pkg.sv
// Shared definitions for the nibble deserializer and the loadable register it
// feeds.
//   state_t       : deserializer FSM encoding (IDLE, DATA, STOP)
//   DEFAULT_WIDTH : word size shared by the deserializer and the register
package nibble_deserializer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/nibble_deserializer.sv
// Serial-to-parallel front end for a WIDTH-bit loadable register.
// Frames are one start bit (0), WIDTH data bits and one stop bit (1). A good
// frame updates D and pulses load for one cycle. A bad stop bit pulses
// frame_err instead and leaves D untouched.
//
// Ports:
//   Clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   sin        in   serial data bit, sampled only while sin_valid=1
//   sin_valid  in   bit strobe, one bit consumed per strobe
//   D          out  last correctly framed word
//   load       out  one-cycle pulse marking D as new
//   frame_err  out  one-cycle pulse on a bad stop bit
//   busy       out  high while a frame is in progress
module nibble_deserializer
    import nibble_deserializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] D,
    output logic             load,
    output logic             frame_err,
    output logic             busy
);

    // WIDTH=2 would give a 1-bit counter anyway; the guard keeps CW >= 1.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load_q, load_d;
    logic             err_q, err_d;

    // State register. Reset wins over any strobe on the same edge, so a stop
    // bit sampled together with reset is discarded.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. Without a strobe everything holds and the two pulse
    // outputs fall back to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        load_d  = 1'b0;
        err_d   = 1'b0;
        if (sin_valid) begin
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    // Shifting right means that after WIDTH shifts the first
                    // bit sits in bit 0. Shifting left puts it in the MSB.
                    if (LSB_FIRST) begin
                        shift_d = {sin, shift_q[WIDTH-1:1]};
                    end else begin
                        shift_d = {shift_q[WIDTH-2:0], sin};
                    end
                    if (cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    // A 0 here is a framing error. It is not taken as the
                    // start bit of a new frame.
                    if (sin) begin
                        data_d = shift_q;
                        load_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign D         = data_q;
    assign load      = load_q;
    assign frame_err = err_q;
    assign busy      = (state_q != IDLE);

endmodule
